// File: rtl/yaw_integrator.sv
// Calibrates a zero-rate gyro offset and integrates corrected yaw rate into a 12-bit heading.
// Define YAW_IR_FUSION_EN to add synchronized guardrail IR corrections of +/-512 per sample.
module yaw_integrator #(
  parameter int unsigned FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cal,
  input  logic        vld,
  input  logic [15:0] yaw_rt,
  input  logic        moving,
  input  logic        lftIR,
  input  logic        rghtIR,
  output logic        cal_done,
  output logic        rdy,
  output logic [11:0] heading
);

  localparam int unsigned CalShift = (FAST_SIM != 0) ? 8 : 11;
  localparam logic [11:0] CalN     = (FAST_SIM != 0) ? 12'd256 : 12'd2048;

  typedef enum logic [1:0] {StIdle, StCal, StRun} state_e;

  state_e             state_q, state_d;
  logic [11:0]        cnt_q, cnt_d;
  logic signed [26:0] cal_acc_q, cal_acc_d;
  logic [15:0]        offset_q, offset_d;
  logic signed [26:0] acc_q, acc_d;
  logic               rdy_q, rdy_d;
  logic               cal_done_q, cal_done_d;

  // Stage-1 sample: raw rate in CAL, saturated corrected rate in RUN.
  logic               s1_vld_q, s1_vld_d;
  logic               s1_cal_q, s1_cal_d;
  logic               s1_last_q, s1_last_d;
  logic               s1_upd_q, s1_upd_d;
  logic               s1_dec_q, s1_dec_d;
  logic               s1_inc_q, s1_inc_d;
  logic [15:0]        s1_val_q, s1_val_d;

  logic               lft_s, rght_s;

`ifdef YAW_IR_FUSION_EN
  logic [1:0] lft_sync_q, rght_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_sync_q  <= 2'b00;
      rght_sync_q <= 2'b00;
    end else begin
      lft_sync_q  <= {lft_sync_q[0], lftIR};
      rght_sync_q <= {rght_sync_q[0], rghtIR};
    end
  end

  assign lft_s  = lft_sync_q[1];
  assign rght_s = rght_sync_q[1];
`else
  logic unused_ir;
  assign unused_ir = lftIR ^ rghtIR;
  assign lft_s     = 1'b0;
  assign rght_s    = 1'b0;
`endif

  logic signed [16:0] diff;
  logic [15:0]        comp;
  logic signed [26:0] s1_ext;
  logic signed [26:0] cal_sum;
  logic signed [26:0] cal_avg;
  logic signed [26:0] corr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cal_acc_d  = cal_acc_q;
    offset_d   = offset_q;
    acc_d      = acc_q;
    rdy_d      = 1'b0;
    cal_done_d = 1'b0;
    s1_vld_d   = 1'b0;
    s1_cal_d   = 1'b0;
    s1_last_d  = 1'b0;
    s1_upd_d   = 1'b0;
    s1_dec_d   = 1'b0;
    s1_inc_d   = 1'b0;
    s1_val_d   = s1_val_q;

    diff = $signed({yaw_rt[15], yaw_rt}) - $signed({offset_q[15], offset_q});
    if (diff[16] != diff[15]) begin
      comp = diff[16] ? 16'h8000 : 16'h7fff;
    end else begin
      comp = diff[15:0];
    end

    s1_ext  = {{11{s1_val_q[15]}}, s1_val_q};
    cal_sum = cal_acc_q + s1_ext;
    cal_avg = cal_sum >>> CalShift;
    if (s1_dec_q) begin
      corr = -27'sd512;
    end else if (s1_inc_q) begin
      corr = 27'sd512;
    end else begin
      corr = '0;
    end

    // Retire the stage-1 sample; a concurrent strt_cal keeps its rdy but drops its effect.
    if (s1_vld_q) begin
      if (!s1_cal_q) begin
        rdy_d = 1'b1;
        if (s1_upd_q && !strt_cal) begin
          acc_d = acc_q + s1_ext + corr;
        end
      end else if (!strt_cal) begin
        cal_acc_d = cal_sum;
        if (s1_last_q) begin
          offset_d   = cal_avg[15:0];
          acc_d      = '0;
          cal_done_d = 1'b1;
          state_d    = StRun;
        end
      end
    end

    if (strt_cal) begin
      state_d   = StCal;
      cnt_d     = '0;
      cal_acc_d = '0;
    end else if (vld) begin
      unique case (state_q)
        StIdle: begin
          s1_vld_d = 1'b1;
        end
        StCal: begin
          // Samples beyond N that arrive before RUN takes effect are dropped.
          if (cnt_q < CalN) begin
            s1_vld_d  = 1'b1;
            s1_cal_d  = 1'b1;
            s1_last_d = (cnt_q == CalN - 12'd1);
            s1_val_d  = yaw_rt;
            cnt_d     = cnt_q + 12'd1;
          end
        end
        StRun: begin
          s1_vld_d = 1'b1;
          s1_val_d = comp;
          s1_upd_d = moving;
          s1_dec_d = moving & lft_s & ~rght_s;
          s1_inc_d = moving & rght_s & ~lft_s;
        end
        default: begin
          s1_vld_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cal_acc_q  <= '0;
      offset_q   <= '0;
      acc_q      <= '0;
      rdy_q      <= 1'b0;
      cal_done_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_cal_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_upd_q   <= 1'b0;
      s1_dec_q   <= 1'b0;
      s1_inc_q   <= 1'b0;
      s1_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cal_acc_q  <= cal_acc_d;
      offset_q   <= offset_d;
      acc_q      <= acc_d;
      rdy_q      <= rdy_d;
      cal_done_q <= cal_done_d;
      s1_vld_q   <= s1_vld_d;
      s1_cal_q   <= s1_cal_d;
      s1_last_q  <= s1_last_d;
      s1_upd_q   <= s1_upd_d;
      s1_dec_q   <= s1_dec_d;
      s1_inc_q   <= s1_inc_d;
      s1_val_q   <= s1_val_d;
    end
  end

  assign rdy      = rdy_q;
  assign cal_done = cal_done_q;
  assign heading  = acc_q[26:15];

endmodule
